// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access controller: size codes,
// FSM state encoding and the store merge helper.
package mem_access_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // Memory always writes a full word, so sub-word stores keep the upper
    // bytes of the old word and replace only the low byte/halfword.
    function automatic logic [WORD_W-1:0] merge_store(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] wdata,
        input size_e             size
    );
        logic [WORD_W-1:0] result;
        case (size)
            SIZE_BYTE: result = {old_word[31:8], wdata[7:0]};
            SIZE_HALF: result = {old_word[31:16], wdata[15:0]};
            default:   result = wdata;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load data extraction: picks the low byte/halfword/word of a
// memory read and sign- or zero-extends it to 32 bits. Shared with the datapath.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [WORD_W-1:0] rd_i,
    input  size_e             size_i,
    input  logic              signed_i,
    output logic [WORD_W-1:0] ext_o
);

    // Extension fill bit comes from the top of the extracted field; ignored for words.
    always_comb begin
        ext_o = '0;
        case (size_i)
            SIZE_BYTE: ext_o = {{24{signed_i & rd_i[7]}}, rd_i[7:0]};
            SIZE_HALF: ext_o = {{16{signed_i & rd_i[15]}}, rd_i[15:0]};
            SIZE_WORD: ext_o = rd_i;
            default:   ext_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a byte-addressed memory with combinational read
// and word-wide posedge write. One request in flight; sub-word stores are
// done as read-modify-write. Responses are a single registered pulse.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 101
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [WORD_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_wd,
    input  logic [WORD_W-1:0]     mem_rd
);

    // Every access touches BYTE_SIZE bytes, so this is the last legal start address.
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(MEM_BYTES - BYTE_SIZE);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    size_e                   size_q;
    logic                    signed_q;
    logic                    we_q;
    logic [WORD_W-1:0]       wdata_q;
    logic                    rsp_valid_q;
    logic                    rsp_err_q;
    logic [WORD_W-1:0]       rsp_rdata_q;

    logic                    req_err_d;
    logic [WORD_W-1:0]       load_ext_d;
    logic [WORD_W-1:0]       merged_d;

    // Request legality: bad size, misalignment or any byte beyond the array.
    always_comb begin
        req_err_d = 1'b0;
        case (req_size)
            2'b11:   req_err_d = 1'b1;
            2'b01:   req_err_d = req_addr[0];
            2'b10:   req_err_d = (req_addr[1:0] != 2'b00);
            default: req_err_d = 1'b0;
        endcase
        if (req_addr > MAX_ADDR) begin
            req_err_d = 1'b1;
        end
    end

    load_extend u_load_extend (
        .rd_i     (mem_rd),
        .size_i   (size_q),
        .signed_i (signed_q),
        .ext_o    (load_ext_d)
    );

    assign merged_d = merge_store(mem_rd, wdata_q, size_q);

    // Main FSM: request latch, RMW sequencing and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            size_q      <= SIZE_BYTE;
            signed_q    <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            // Response fields are a one-cycle pulse; zero unless set below.
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        size_q   <= size_e'(req_size);
                        signed_q <= req_signed;
                        we_q     <= req_we;
                        wdata_q  <= req_wdata;
                        if (req_err_d) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (req_we && (size_e'(req_size) == SIZE_WORD)) begin
                            state_q <= ST_WRITE;
                        end else begin
                            // Loads and sub-word stores both need the current word.
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (we_q) begin
                        wdata_q <= merged_d;
                        state_q <= ST_WRITE;
                    end else begin
                        rsp_rdata_q <= load_ext_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    // Write strobe is suppressed combinationally so a reset edge never commits a write.
    assign mem_we   = (state_q == ST_WRITE) && !reset;
    assign mem_addr = ((state_q == ST_READ) || (state_q == ST_WRITE)) ? addr_q : '0;
    assign mem_wd   = (state_q == ST_WRITE) ? wdata_q : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed + randomized bench for mem_access_ctrl with a byte-array memory and
// a byte-level reference model of the memory contents.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [7:0]  dut_mem [0:100];
    logic [7:0]  ref_mem [0:100];
    logic        init_req;

    int          total_cnt = 0;
    int          pass_cnt  = 0;
    int          txn_cnt   = 0;

    mem_access_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational little-endian read, word write on posedge.
    assign mem_rd = (mem_addr <= 32'd97) ?
        {dut_mem[mem_addr[6:0] + 7'd3], dut_mem[mem_addr[6:0] + 7'd2],
         dut_mem[mem_addr[6:0] + 7'd1], dut_mem[mem_addr[6:0]]} : 32'h0;

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 101; i++) dut_mem[i] <= ref_mem[i];
        end else if (mem_we && mem_addr <= 32'd97) begin
            dut_mem[mem_addr[6:0]]         <= mem_wd[7:0];
            dut_mem[mem_addr[6:0] + 7'd1]  <= mem_wd[15:8];
            dut_mem[mem_addr[6:0] + 7'd2]  <= mem_wd[23:16];
            dut_mem[mem_addr[6:0] + 7'd3]  <= mem_wd[31:24];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference rules: accesses of 2^size bytes must be size-aligned, size 3 is
    // illegal and the 4-byte memory window must fit inside 101 bytes.
    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if ((a % (32'd1 << sz)) != 0) return 1'b1;
        return (a + 32'd4 > 32'd101);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int nb;
        logic [31:0] v;
        nb = 1 << sz;
        v  = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
        if (sg && nb < 4 && v[8 * nb - 1]) v = v - (32'd1 << (8 * nb));
        return v;
    endfunction

    // One request through the handshake; checks latency, response and write activity.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] got);
        logic        e;
        logic        g_err;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        int          exp_lat;
        int          exp_wec;
        int          lat;
        int          wec;
        int          n;
        int          nb;
        e       = model_err(sz, addr);
        nb      = 1 << sz;
        exp_rd  = (e || we) ? 32'h0 : model_load(addr, sz, sg);
        exp_wd  = 32'h0;
        if (!e) begin
            exp_wd = model_load(addr, 2'd2, 1'b0);
            for (int i = 0; i < nb; i++) exp_wd[8 * i +: 8] = wd[8 * i +: 8];
        end
        exp_lat = e ? 1 : ((we && sz != 2'd2) ? 3 : 2);
        exp_wec = (we && !e) ? 1 : 0;

        n = 0;
        while (!req_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("ready_idle", {31'b0, req_ready}, 32'd1);
        check("addr_idle", mem_addr, 32'h0);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;

        lat   = 0;
        wec   = 0;
        got   = 32'h0;
        g_err = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_we) begin
                wec++;
                check("store_addr", mem_addr, addr);
                check("store_wd", mem_wd, exp_wd);
            end
            if (rsp_valid) begin
                lat   = k;
                got   = rsp_rdata;
                g_err = rsp_err;
                check("busy_ready", {31'b0, req_ready}, 32'd0);
                break;
            end
            check("quiet_rdata", rsp_rdata, 32'h0);
            check("quiet_err", {31'b0, rsp_err}, 32'd0);
        end
        check("latency", lat, exp_lat);
        check("rsp_err", {31'b0, g_err}, {31'b0, e});
        check("rsp_rdata", got, exp_rd);
        check("we_cycles", wec, exp_wec);
        @(negedge clk);
        check("ready_after", {31'b0, req_ready}, 32'd1);
        check("pulse_len", {31'b0, rsp_valid}, 32'd0);

        if (we && !e) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wd[8 * i +: 8];
        end
        txn_cnt++;
        $display("txn %0d we=%0d size=%0d signed=%0d addr=%h wdata=%h lat=%0d err=%0d rdata=%h",
                 txn_cnt, we, sz, sg, addr, wd, lat, g_err, got);
    endtask

    logic [31:0] got;
    logic [31:0] exp_v;
    logic [7:0]  old_b;
    int          n;

    initial begin
        reset      = 1'b1;
        init_req   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 101; i++) ref_mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_err", {31'b0, rsp_err}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        init_req = 1'b0;
        reset    = 1'b0;
        @(negedge clk);

        // Word store/load, byte RMW store, extension cases.
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
        check("word_load", got, 32'hDEADBEEF);
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000007F, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
        check("byte_merge", got, 32'hDEAD7FEF);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, got);
        check("lb_signed", got, 32'hFFFFFFDE);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, got);
        check("lb_unsigned", got, 32'h000000DE);
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, got);
        check("lh_signed", got, 32'hFFFFDEAD);
        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'hAAAA1234, got);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, got);
        check("half_merge", got, 32'h00001234);

        // Error and boundary cases.
        do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, got);
        do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h12345678, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h64, 32'h0, got);
        do_req(1'b1, 2'd0, 1'b0, 32'd98, 32'h11, got);
        do_req(1'b1, 2'd0, 1'b0, 32'd97, 32'h5A, got);
        do_req(1'b1, 2'd2, 1'b0, 32'd96, 32'hCAFEF00D, got);
        do_req(1'b0, 2'd2, 1'b0, 32'd96, 32'h0, got);
        check("top_word", got, 32'hCAFEF00D);

        // Reset during the write cycle of a sub-word store aborts it.
        while (!req_ready) @(negedge clk);
        old_b      = ref_mem[32];
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'h20;
        req_wdata  = {24'h0, ~old_b};
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_we && n < 6);
        check("rst_we_seen", {31'b0, mem_we}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid_valid", {31'b0, rsp_valid}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        check("rst_mem_kept", {24'h0, dut_mem[32]}, {24'h0, old_b});
        $display("txn reset-abort byte store addr=00000020 mem=%h", dut_mem[32]);

        // Back-to-back: req_valid held across two identical word loads.
        exp_v      = model_load(32'h10, 2'd2, 1'b0);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h10;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b2b_busy1", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("b2b_busy2", {31'b0, req_ready}, 32'd0);
        check("b2b_rsp1", {31'b0, rsp_valid}, 32'd1);
        check("b2b_data1", rsp_rdata, exp_v);
        @(negedge clk);
        check("b2b_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_wait", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("b2b_rsp2", {31'b0, rsp_valid}, 32'd1);
        check("b2b_data2", rsp_rdata, exp_v);
        $display("txn back-to-back word loads addr=00000010 rdata=%h", exp_v);
        @(negedge clk);

        // Randomized traffic against the byte-level model.
        for (int t = 0; t < 200; t++) begin
            logic        r_we;
            logic        r_sg;
            logic [1:0]  r_sz;
            logic [31:0] r_addr;
            int          r;
            r_we = 1'($urandom);
            r_sg = 1'($urandom);
            r    = $urandom_range(0, 15);
            r_sz = (r == 0) ? 2'd3 : 2'(r % 3);
            r_addr = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 100));
            if ($urandom_range(0, 1) == 1 && r_sz != 2'd3)
                r_addr = r_addr & ~((32'd1 << r_sz) - 32'd1);
            do_req(r_we, r_sz, r_sg, r_addr, $urandom, got);
        end

        for (int i = 0; i < 101; i++)
            check($sformatf("mem_%0d", i), {24'h0, dut_mem[i]}, {24'h0, ref_mem[i]});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
